// File: rtl/mic_pkg.sv
// Shared types and frame constants for the Pmod MIC3 (ADCS7476) sampler.
package mic_pkg;

  // SPI read sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    QUIET    = 2'd3
  } state_t;

  // ADCS7476 frame: 4 leading zeros followed by 12 data bits, MSB first
  localparam int FRAME_BITS = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DEF_DATA_W = 12;

  // Unsigned maximum of two samples (offset-binary compares as plain unsigned)
  function automatic logic [DEF_DATA_W-1:0] umax(input logic [DEF_DATA_W-1:0] a,
                                                 input logic [DEF_DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mic_peak_tracker.sv
// Windowed peak detector: reports the largest sample seen in each block of
// PEAK_WINDOW samples, then restarts from zero for the next block.
module mic_peak_tracker
  import mic_pkg::*;
#(
  parameter int PEAK_WINDOW = 4000,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] peak,
  output logic              peak_valid
);

  localparam int CNT_W = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PEAK_WINDOW - 1);

  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] max_val;

  // The incoming sample is included in the window it closes.
  assign max_val = (sample > acc) ? sample : acc;

  // Accumulate the running maximum; publish and clear on the last sample of a window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      acc        <= '0;
      peak       <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (sample_valid) begin
        if (count == LAST_IDX) begin
          peak       <= max_val;
          peak_valid <= 1'b1;
          acc        <= '0;
          count      <= '0;
        end else begin
          acc   <= max_val;
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mic_spi_sampler.sv
// Pmod MIC3 sampler: each rising edge of sample_clk starts one 16-bit SPI read
// of the ADCS7476, publishes the 12-bit result with a one-cycle valid pulse and
// feeds a windowed peak detector used by the volume / display logic.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a sample_clk rising edge
// CS_SETUP | cs_n low, sclk high for one half-period before the first bit
// SHIFT    | 16 bits, each a low half then a high half; MISO taken at the
//          | last cycle of every high half
// QUIET    | cs_n high for one half-period before the next frame may start
module mic_spi_sampler
  import mic_pkg::*;
#(
  parameter int SCLK_HALF_DIV = 25,
  parameter int PEAK_WINDOW   = 4000,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic              sample_clk,
  input  logic              mic_miso,
  output logic              mic_cs_n,
  output logic              mic_sclk,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic [DATA_W-1:0] peak,
  output logic              peak_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int HALF_W = $clog2(SCLK_HALF_DIV);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(SCLK_HALF_DIV - 1);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam int DATA_MSB = FRAME_BITS - LEAD_ZEROS - 1;

  state_t                  state;
  logic                    sc_prev;
  logic                    miso_meta;
  logic                    miso_sync;
  logic                    trigger;
  logic [HALF_W-1:0]       half_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [FRAME_BITS-1:0]   shift_next;
  logic                    unused_lead;

  assign trigger    = sample_clk & ~sc_prev;
  assign shift_next = {shift_reg[FRAME_BITS-2:0], miso_sync};
  // The oldest frame bit is always a leading zero and simply falls off.
  assign unused_lead = shift_reg[FRAME_BITS-1];

  // Edge-detect history and 2-flop MISO synchronizer; sc_prev resets high so a
  // sample_clk already high at reset release is not taken as an edge
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      sc_prev   <= 1'b1;
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      sc_prev   <= sample_clk;
      miso_meta <= mic_miso;
      miso_sync <= miso_meta;
    end
  end

  // SPI read sequencer with registered cs_n, sclk, sample, valid, busy, overrun
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state        <= IDLE;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      mic_cs_n     <= 1'b1;
      mic_sclk     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (trigger && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= CS_SETUP;
            mic_cs_n <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= HALF_LOAD;
          end
        end
        CS_SETUP: begin
          if (half_cnt == '0) begin
            state    <= SHIFT;
            mic_sclk <= 1'b0;
            half_cnt <= HALF_LOAD;
            bit_cnt  <= '0;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - 1'b1;
          end else begin
            half_cnt <= HALF_LOAD;
            if (!mic_sclk) begin
              mic_sclk <= 1'b1;
            end else begin
              shift_reg <= shift_next;
              if (bit_cnt == LAST_BIT) begin
                // sclk stays high: it is already at its idle level
                state        <= QUIET;
                mic_cs_n     <= 1'b1;
                sample       <= shift_next[DATA_MSB -: DATA_W];
                sample_valid <= 1'b1;
              end else begin
                mic_sclk <= 1'b0;
                bit_cnt  <= bit_cnt + 1'b1;
              end
            end
          end
        end
        QUIET: begin
          if (half_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          mic_cs_n <= 1'b1;
          mic_sclk <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  mic_peak_tracker #(
    .PEAK_WINDOW (PEAK_WINDOW),
    .DATA_W      (DATA_W)
  ) u_peak (
    .clk          (CLOCK),
    .rst_n        (RESETN),
    .sample       (sample),
    .sample_valid (sample_valid),
    .peak         (peak),
    .peak_valid   (peak_valid)
  );

endmodule
